keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles each column is driven (1 ms at 100 MHz); legal range 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans required to accept a state; legal range 1 to 15.
REQ-003 SHALL have parameter REPEAT_SCANS, default 250; it applies only with KEYPAD_AUTOREPEAT_EN.
REQ-004 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: col_n  output  4  active-low column drive, one-hot-low; bit i is keypad column C(i+1).
REQ-007 SHALL have port: row_n  input  4  active-low row sense, asynchronous; bit i is keypad row R(i+1).
REQ-008 SHALL have port: key_code  output  4  hex value of the accepted key.
REQ-009 SHALL have port: key_down  output  1  high while an accepted key is held.
REQ-010 SHALL have port: key_pulse  output  1  one-cycle strobe on each accepted press.

Function
REQ-011 SHALL pass row_n through a 2-flop synchronizer before any use.
REQ-012 SHALL use a dwell counter that counts 0..SCAN_DIV-1 per column; at count SCAN_DIV-1 it samples the synchronized rows into the 4-bit map slot for the current column, then advances the column 0->1->2->3->0.
REQ-013 SHALL drive col_n as 1110, 1101, 1011, 0111 for columns 0-3, changing only on the cycle after a sample.
REQ-014 SHALL treat the column-3 sample as scan end and form a 16-bit map for that scan; key index = row*4+col.
REQ-015 SHALL encode the map into a candidate: "none" if no bit is set, otherwise the lowest set index (row-major priority).
REQ-016 SHALL decode keys by row: R1 = 1,2,3,A; R2 = 4,5,6,B; R3 = 7,8,9,C; R4 = 0,F,E,D (columns C1..C4).
REQ-017 SHALL, at each scan end, increment a saturating stable counter if the candidate equals the previous scan's candidate; otherwise it SHALL reset the counter to 1.
REQ-018 SHALL accept a candidate on the scan end where the stable counter first reaches DEBOUNCE_SCANS.
REQ-019 SHALL, on accepting a key when key_down=0 or the code differs, load key_code, set key_down=1, and assert key_pulse for exactly one cycle, coincident with the key_code update.
REQ-020 SHALL, on accepting "none", clear key_down, leave key_code holding its last value, and not pulse.
REQ-021 SHALL generate no pulse and make no output change when the same accepted key is re-accepted.
REQ-022 SHALL give a latency of at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles from a steady press to key_pulse.
REQ-023 SHALL produce a single pulse for the priority key when several keys are held, and a new pulse if that priority key changes and is stable.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set: col_n=1110, dwell counter=0, column=0, map=0, previous candidate=none, stable counter=0, key_code=0, key_down=0, key_pulse=0, synchronizer=1111.
REQ-025 SHALL, on rst mid-scan, abandon the partial scan, and the first post-reset scan SHALL start at column 0 with the dwell counter at 0.

Configuration
REQ-026 SHALL, with KEYPAD_AUTOREPEAT_EN defined, also assert key_pulse (same key_code) every REPEAT_SCANS scan ends after the accepting scan, while the same key stays accepted and held.
REQ-027 SHALL, without KEYPAD_AUTOREPEAT_EN, give exactly one key_pulse per accepted press and contain no repeat counter logic.

Structure
REQ-028 SHALL place key code constants, the 16-entry index-to-hex table, and the "none" encoding in shared package keypad_pkg.
REQ-029 SHALL implement the stable counter and acceptance logic (REQ-017 to REQ-021, REQ-026) in sub-module keypad_debounce; the scan timer and encoder stay in keypad_scanner.

Verification
REQ-030 SHALL run the bench with SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3. Its keypad model pulls row_n[r] low only while col_n[c] is low for a pressed (r,c).
REQ-031 SHALL cover: reset then idle for 10 scans -> col_n cycles 1110/1101/1011/0111 every 4 cycles; key_down=0, key_pulse never asserted.
REQ-032 SHALL cover: all 16 keys pressed for 5 scans each with releases between -> key_codes 1,2,3,A,4,5,6,B,7,8,9,C,0,F,E,D, one pulse each, latency within REQ-022.
REQ-033 SHALL cover: press (R2,C3) for 1 scan only -> no pulse; then held 3 scans -> one pulse, key_code=6.
REQ-034 SHALL cover: hold (R1,C4) and (R3,C1) together -> key_code=A only; release (R1,C4) -> pulse with key_code=7.
REQ-035 SHALL cover: rst asserted mid-column-2 during press of 5 -> outputs at reset values next cycle; after release of rst, held 5 -> pulse within REQ-022 bound. With KEYPAD_AUTOREPEAT_EN, holding 5 for 12 scans -> pulses at the accepting scan and every 3 scans after.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scan column states, candidate encoding and the
// key-index (row*4+col) to hex lookup table.
package keypad_pkg;

   typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_t;

   // Candidate is {none, index}; index is only meaningful when none is 0.
   localparam logic [4:0] CAND_NONE = 5'b1_0000;

   // Nibble n holds the hex code of key index n (rows R1..R4, columns C1..C4).
   localparam logic [63:0] KEY_TABLE = {
      4'hD, 4'hE, 4'hF, 4'h0,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [3:0] key_hex(input logic [3:0] idx);
      logic [5:0] base;
      base = {idx, 2'b00};
      return KEY_TABLE[base +: 4];
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debounce and key acceptance; optional auto-repeat is enabled by
// defining KEYPAD_AUTOREPEAT_EN.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_SCANS = 250
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_end_i,
   input  logic [4:0] cand_i,
   output logic [3:0] key_code_o,
   output logic       key_down_o,
   output logic       key_pulse_o
);

   logic [4:0] prev_q;
   logic [3:0] stable_q;
   logic [3:0] stable_d;
   logic [3:0] key_code_q;
   logic       key_down_q;
   logic       key_pulse_q;
   logic       same;
   logic       accept;
   logic [3:0] cand_hex;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [15:0] REP_LAST = 16'(REPEAT_SCANS - 1);
   logic [15:0] rep_q;
`endif

   always_comb begin
      same     = (cand_i == prev_q);
      stable_d = 4'd1;
      if (same) begin
         stable_d = (stable_q == 4'hF) ? 4'hF : stable_q + 4'd1;
      end
      // Accept only on the scan where the count first hits the threshold,
      // including the saturated case where it would otherwise stay there.
      accept   = (stable_d == 4'(DEBOUNCE_SCANS)) &&
                 !(same && (stable_q == 4'(DEBOUNCE_SCANS)));
      cand_hex = key_hex(cand_i[3:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q      <= CAND_NONE;
         stable_q    <= '0;
         key_code_q  <= '0;
         key_down_q  <= 1'b0;
         key_pulse_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         key_pulse_q <= 1'b0;
         if (scan_end_i) begin
            prev_q   <= cand_i;
            stable_q <= stable_d;
            if (accept) begin
`ifdef KEYPAD_AUTOREPEAT_EN
               rep_q <= '0;
`endif
               if (cand_i[4]) begin
                  key_down_q <= 1'b0;
               end else if (!key_down_q || (cand_hex != key_code_q)) begin
                  key_code_q  <= cand_hex;
                  key_down_q  <= 1'b1;
                  key_pulse_q <= 1'b1;
               end
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (key_down_q && !cand_i[4] && (cand_hex == key_code_q)) begin
               if (rep_q == REP_LAST) begin
                  rep_q       <= '0;
                  key_pulse_q <= 1'b1;
               end else begin
                  rep_q <= rep_q + 16'd1;
               end
            end else begin
               rep_q <= '0;
            end
`endif
         end
      end
   end

   assign key_code_o  = key_code_q;
   assign key_down_o  = key_down_q;
   assign key_pulse_o = key_pulse_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, priority encoding.
// Define KEYPAD_AUTOREPEAT_EN to enable held-key auto-repeat pulses.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned REPEAT_SCANS   = 250
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] col_n,
   input  logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_down,
   output logic       key_pulse
);

   localparam int unsigned   DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
   begin : g_bad_params
      $error("keypad_scanner: parameter out of range");
   end

   logic [3:0]    sync1_q;
   logic [3:0]    sync2_q;
   logic [DW-1:0] dwell_q;
   col_t          col_q;
   col_t          col_next;
   logic [3:0]    col_n_q;
   logic [15:0]   map_q;
   logic [15:0]   map_d;
   logic          scan_end_q;
   logic [4:0]    cand_q;
   logic [4:0]    cand_d;

   // map_d is the map as it would be after sampling the current column now.
   always_comb begin
      map_d = map_q;
      for (int unsigned r = 0; r < 4; r++) begin
         map_d[{2'(r), col_q}] = ~sync2_q[r];
      end
      cand_d = CAND_NONE;
      for (int unsigned i = 16; i > 0; i--) begin
         if (map_d[i-1]) cand_d = {1'b0, 4'(i - 1)};
      end
      case (col_q)
         COL0:    col_next = COL1;
         COL1:    col_next = COL2;
         COL2:    col_next = COL3;
         default: col_next = COL0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         dwell_q    <= '0;
         col_q      <= COL0;
         col_n_q    <= 4'b1110;
         map_q      <= '0;
         scan_end_q <= 1'b0;
         cand_q     <= CAND_NONE;
      end else begin
         sync1_q    <= row_n;
         sync2_q    <= sync1_q;
         scan_end_q <= 1'b0;
         if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            map_q   <= map_d;
            col_q   <= col_next;
            col_n_q <= ~(4'b0001 << col_next);
            if (col_q == COL3) begin
               scan_end_q <= 1'b1;
               cand_q     <= cand_d;
            end
         end else begin
            dwell_q <= dwell_q + 1'b1;
         end
      end
   end

   assign col_n = col_n_q;

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
`ifdef KEYPAD_AUTOREPEAT_EN
      ,
      .REPEAT_SCANS   (REPEAT_SCANS)
`endif
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .scan_end_i  (scan_end_q),
      .cand_i      (cand_q),
      .key_code_o  (key_code),
      .key_down_o  (key_down),
      .key_pulse_o (key_pulse)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a matrix keypad model and a
// pulse scoreboard; also covers auto-repeat when KEYPAD_AUTOREPEAT_EN is set.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEB      = 2;
   localparam int unsigned REP      = 3;
   localparam int unsigned SCAN_CYC = 4 * SCAN_DIV;
   localparam int unsigned LAT_MAX  = (DEB + 1) * 4 * SCAN_DIV + 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic [3:0]  key_code;
   logic        key_down;
   logic        key_pulse;
   logic [15:0] keys = '0;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  last_code = 4'h0;
   logic [3:0]  HEX_OF [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

   always #5 clk = ~clk;

   // Keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_n = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
   end

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB),
      .REPEAT_SCANS   (REP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col_n     (col_n),
      .row_n     (row_n),
      .key_code  (key_code),
      .key_down  (key_down),
      .key_pulse (key_pulse)
   );

   // Scoreboard: every pulse pops the oldest expected code.
   always @(negedge clk) begin
      logic [3:0] e;
      if (!rst && key_pulse === 1'b1) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (key_code !== e) begin
               bad++;
               $display("FAIL pulse_code: key_code=%h expected=%h", key_code, e);
            end
            last_code = e;
         end else begin
            total++;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (key_code !== last_code || key_down !== 1'b1) begin
               bad++;
               $display("FAIL repeat_code: key_code=%h key_down=%b expected=%h/1",
                        key_code, key_down, last_code);
            end
`else
            bad++;
            $display("FAIL unexpected_pulse: key_code=%h expected no pulse", key_code);
`endif
         end
      end
   end

   task automatic wait_pulse(input int unsigned hold, input int unsigned limit,
                             output bit got, output int unsigned lat);
      got = 1'b0;
      lat = 0;
      for (int unsigned i = 1; i <= limit; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!got && key_pulse === 1'b1) begin
            got = 1'b1;
            lat = i;
         end
         if (i == hold) keys = '0;
         if (got && i >= hold) break;
      end
      if (!got && exp_q.size() != 0) exp_q.delete(exp_q.size() - 1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (col_n !== 4'b1110) begin bad++; $display("FAIL reset_col_n: got %b want 1110", col_n); end
      total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_key_code: got %h want 0", key_code); end
      total++; if (key_down !== 1'b0) begin bad++; $display("FAIL reset_key_down: got %b want 0", key_down); end
      total++; if (key_pulse !== 1'b0) begin bad++; $display("FAIL reset_key_pulse: got %b want 0", key_pulse); end
   endtask

   task automatic test_idle();
      logic [3:0] exp_col;
      logic [3:0] one;
      rst = 1'b0;
      one = 4'b0001;
      for (int unsigned k = 1; k <= 10 * SCAN_CYC; k++) begin
         @(posedge clk);
         @(negedge clk);
         exp_col = ~(one << ((k / SCAN_DIV) % 4));
         total++;
         if (col_n !== exp_col) begin
            bad++; $display("FAIL idle_col_n: cycle %0d got %b want %b", k, col_n, exp_col);
         end
         total++;
         if ({key_down, key_pulse} !== 2'b00) begin
            bad++; $display("FAIL idle_outputs: cycle %0d down/pulse=%b%b want 00", k, key_down, key_pulse);
         end
      end
   endtask

   task automatic test_all_keys();
      bit got;
      int unsigned lat;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(HEX_OF[i]);
         keys = 16'(1) << i;
         wait_pulse(5 * SCAN_CYC, 5 * SCAN_CYC, got, lat);
         total++;
         if (!got) begin
            bad++; $display("FAIL key%0d_pulse: no pulse within %0d cycles", i, 5 * SCAN_CYC);
         end else if (lat > LAT_MAX) begin
            bad++; $display("FAIL key%0d_latency: got %0d cycles want <= %0d", i, lat, LAT_MAX);
         end
         repeat (4 * SCAN_CYC) @(negedge clk);
         total++;
         if (key_down !== 1'b0) begin bad++; $display("FAIL key%0d_release: key_down=%b want 0", i, key_down); end
         total++;
         if (key_code !== HEX_OF[i]) begin
            bad++; $display("FAIL key%0d_hold_code: key_code=%h want %h", i, key_code, HEX_OF[i]);
         end
      end
   endtask

   task automatic test_short_press();
      bit got;
      int unsigned lat;
      keys = 16'(1) << 6;
      repeat (SCAN_CYC) @(negedge clk);
      keys = '0;
      repeat (3 * SCAN_CYC) @(negedge clk);
      total++;
      if (key_down !== 1'b0) begin bad++; $display("FAIL short_press_down: key_down=%b want 0", key_down); end
      exp_q.push_back(4'h6);
      keys = 16'(1) << 6;
      wait_pulse(3 * SCAN_CYC, LAT_MAX + 4, got, lat);
      total++;
      if (!got || lat > LAT_MAX) begin
         bad++; $display("FAIL short_then_hold: got=%0b lat=%0d want pulse within %0d", got, lat, LAT_MAX);
      end
      repeat (4 * SCAN_CYC) @(negedge clk);
      total++;
      if (key_code !== 4'h6) begin bad++; $display("FAIL short_code: key_code=%h want 6", key_code); end
   endtask

   task automatic test_multi_key();
      bit got;
      int unsigned lat;
      exp_q.push_back(4'hA);
      keys = (16'(1) << 3) | (16'(1) << 8);
      wait_pulse(0, LAT_MAX + 4, got, lat);
      total++;
      if (!got) begin bad++; $display("FAIL multi_first: no pulse within %0d cycles", LAT_MAX + 4); end
      repeat (SCAN_CYC) @(negedge clk);
      exp_q.push_back(4'h7);
      keys = 16'(1) << 8;
      wait_pulse(0, LAT_MAX + 4, got, lat);
      total++;
      if (!got) begin bad++; $display("FAIL multi_second: no pulse within %0d cycles", LAT_MAX + 4); end
      total++;
      if (key_code !== 4'h7) begin bad++; $display("FAIL multi_code: key_code=%h want 7", key_code); end
      keys = '0;
      repeat (4 * SCAN_CYC) @(negedge clk);
      total++;
      if (key_down !== 1'b0) begin bad++; $display("FAIL multi_release: key_down=%b want 0", key_down); end
   endtask

   task automatic test_mid_reset();
      bit got;
      bit found;
      int unsigned lat;
      exp_q.push_back(4'h5);
      keys = 16'(1) << 5;
      wait_pulse(0, LAT_MAX + 4, got, lat);
      total++;
      if (!got) begin bad++; $display("FAIL reset_prepress: no pulse within %0d cycles", LAT_MAX + 4); end
      found = 1'b0;
      for (int unsigned i = 0; i < 2 * SCAN_CYC; i++) begin
         @(negedge clk);
         if (col_n === 4'b1011) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("FAIL reset_find_col2: col_n=%b never reached 1011", col_n); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({col_n, key_code, key_down, key_pulse} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL midreset_outputs: col_n=%b code=%h down=%b pulse=%b want 1110/0/0/0",
                         col_n, key_code, key_down, key_pulse);
      end
      rst = 1'b0;
      exp_q.push_back(4'h5);
      wait_pulse(0, LAT_MAX + 4, got, lat);
      total++;
      if (!got || lat > LAT_MAX) begin
         bad++; $display("FAIL postreset_latency: got=%0b lat=%0d want pulse within %0d", got, lat, LAT_MAX);
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      begin
         int unsigned reps;
         int unsigned last;
         reps = 0;
         last = lat;
         for (int unsigned i = lat + 1; i <= 12 * SCAN_CYC; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_pulse === 1'b1) begin
               reps++;
               total++;
               if (i - last != REP * SCAN_CYC) begin
                  bad++; $display("FAIL repeat_spacing: %0d cycles want %0d", i - last, REP * SCAN_CYC);
               end
               last = i;
            end
         end
         total++;
         if (reps != 3) begin bad++; $display("FAIL repeat_count: got %0d want 3", reps); end
      end
`endif
      keys = '0;
      repeat (4 * SCAN_CYC) @(negedge clk);
      total++;
      if (key_down !== 1'b0) begin bad++; $display("FAIL midreset_release: key_down=%b want 0", key_down); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle();
      test_all_keys();
      test_short_press();
      test_multi_key();
      test_mid_reset();
      repeat (2 * SCAN_CYC) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain: %0d expected pulses never seen, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
